// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler
//
// Paces an ADC at a fixed sample rate. Every CLK_DIV clocks (while enabled) a tick
// launches a one-beat command on the command stream. The block then waits for the
// matching response and republishes its data as a one-cycle sample pulse. A tick
// that arrives while a conversion is still running is dropped and recorded in the
// sticky overrun flag.
//
// Build option: define ADC_SCHED_TIMEOUT_EN to add a response watchdog. When the
// watchdog expires the conversion is abandoned and the sticky timeout flag is set.
// Without the macro the block waits for the response indefinitely and timeout is 0.
//
// Parameters
//   CLK_DIV         clocks per sample tick, 4..65535
//   CHANNEL         ADC channel requested and accepted (5 bits)
//   TIMEOUT_CYCLES  watchdog limit in WAIT_RSP cycles (only used with the macro)
//
// Ports
//   clock_clk              single clock
//   reset_sink_reset       synchronous active-high reset
//   enable                 run the sample tick counter
//   clear_flags            clear overrun / timeout (a same-cycle set wins)
//   command_valid          command request, held until command_ready
//   command_channel        constant CHANNEL
//   command_startofpacket  equal to command_valid (single-beat packets)
//   command_endofpacket    equal to command_valid
//   command_ready          ADC accepts the command
//   response_valid         ADC result valid
//   response_channel       channel of the result
//   response_data          conversion result
//   sample_valid           one-cycle pulse, new sample present
//   sample_data            last accepted sample, held between pulses
//   busy                   high whenever a conversion is in flight
//   overrun                sticky, a tick was dropped
//   timeout                sticky, the response watchdog expired

module adc_sample_scheduler #(
  parameter int unsigned CLK_DIV        = 3125,
  parameter int unsigned CHANNEL        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock_clk,
  input  logic        reset_sink_reset,
  input  logic        enable,
  input  logic        clear_flags,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  localparam logic [15:0] TickLast = 16'(CLK_DIV - 1);
  localparam logic [4:0]  Chan     = 5'(CHANNEL);

  // Elaboration-time parameter legality checks.
  if (CLK_DIV < 4 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("adc_sample_scheduler: CLK_DIV must be within 4..65535");
  end
  if (CHANNEL > 31) begin : g_bad_channel
    $error("adc_sample_scheduler: CHANNEL must fit in 5 bits");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("adc_sample_scheduler: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWaitRsp,
    StOut
  } state_e;

  state_e      state_q;
  logic [15:0] tick_cnt_q;
  logic        command_valid_q;
  logic        sample_valid_q;
  logic [11:0] sample_data_q;
  logic        overrun_q;

  logic        tick;
  logic        rsp_hit;
  logic        tick_dropped;
  logic        wd_expire;

  // ---------------------------------------------------------------------------
  // Sample tick counter: held at 0 while disabled so re-enabling always yields a
  // full CLK_DIV period before the first tick.
  // ---------------------------------------------------------------------------
  assign tick = enable && (tick_cnt_q == TickLast);

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset || !enable) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  // Only a response for our channel is accepted; everything else is noise.
  assign rsp_hit      = response_valid && (response_channel == Chan);
  assign tick_dropped = tick && (state_q != StIdle);

  // ---------------------------------------------------------------------------
  // Optional response watchdog.
  // ---------------------------------------------------------------------------
`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int unsigned    WdW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wdog_q;
  logic           timeout_q;

  // wdog_q holds the number of WAIT_RSP cycles already spent, so the limit is hit
  // during the TIMEOUT_CYCLES-th cycle. A response in that cycle still wins.
  assign wd_expire = (state_q == StWaitRsp) && !rsp_hit && (wdog_q == WdLast);

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // Held at 0 outside WAIT_RSP, which clears it on every entry.
      if (state_q != StWaitRsp) begin
        wdog_q <= '0;
      end else if (!wd_expire) begin
        wdog_q <= wdog_q + 1'b1;
      end
      timeout_q <= (timeout_q & ~clear_flags) | wd_expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Conversion FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      state_q         <= StIdle;
      command_valid_q <= 1'b0;
      sample_valid_q  <= 1'b0;
      sample_data_q   <= '0;
      overrun_q       <= 1'b0;
    end else begin
      // Set beats clear when both happen in the same cycle.
      overrun_q      <= (overrun_q & ~clear_flags) | tick_dropped;
      sample_valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (tick) begin
            state_q         <= StCmd;
            command_valid_q <= 1'b1;
          end
        end

        StCmd: begin
          if (command_ready) begin
            state_q         <= StWaitRsp;
            command_valid_q <= 1'b0;
          end
        end

        StWaitRsp: begin
          if (rsp_hit) begin
            state_q        <= StOut;
            sample_data_q  <= response_data;
            sample_valid_q <= 1'b1;
          end else if (wd_expire) begin
            state_q <= StIdle;
          end
        end

        StOut: begin
          state_q <= StIdle;
        end

        default: begin
          state_q         <= StIdle;
          command_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign command_valid         = command_valid_q;
  assign command_startofpacket = command_valid_q;
  assign command_endofpacket   = command_valid_q;
  assign command_channel       = Chan;
  assign sample_valid          = sample_valid_q;
  assign sample_data           = sample_data_q;
  assign busy                  = (state_q != StIdle);
  assign overrun               = overrun_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Testbench for adc_sample_scheduler (CLK_DIV=8, CHANNEL=1, TIMEOUT_CYCLES=16).
// Directed table and sequences plus randomized traffic checked every cycle
// against a rule-level reference model.

module tb_adc_sample_scheduler;

  localparam int unsigned CLK_DIV        = 8;
  localparam int unsigned CHANNEL        = 1;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic        ready;
  logic        rsp_valid;
  logic [4:0]  rsp_ch;
  logic [11:0] rsp_data;

  logic        command_valid;
  logic [4:0]  command_channel;
  logic        command_startofpacket;
  logic        command_endofpacket;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic        busy;
  logic        overrun;
  logic        timeout;

  always #5 clk = ~clk;

  adc_sample_scheduler #(
    .CLK_DIV        (CLK_DIV),
    .CHANNEL        (CHANNEL),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock_clk             (clk),
    .reset_sink_reset      (rst),
    .enable                (en),
    .clear_flags           (clr),
    .command_valid         (command_valid),
    .command_channel       (command_channel),
    .command_startofpacket (command_startofpacket),
    .command_endofpacket   (command_endofpacket),
    .command_ready         (ready),
    .response_valid        (rsp_valid),
    .response_channel      (rsp_ch),
    .response_data         (rsp_data),
    .sample_valid          (sample_valid),
    .sample_data           (sample_data),
    .busy                  (busy),
    .overrun               (overrun),
    .timeout               (timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: conversion progress described by the rules, not by states.
  //   m_want  - a command is being requested (tick seen, not yet accepted)
  //   m_await - command accepted, response outstanding
  //   m_pulse - sample presented this cycle
  bit          m_want, m_await, m_pulse, m_ovr, m_to;
  logic [11:0] m_data;
  int          m_run;   // consecutive enabled cycles since counter restart
  int          m_wait;  // cycles already spent awaiting the response

  function automatic void model_edge();
    bit tick, idle, hit, expire, n_want, n_await;
    if (rst) begin
      m_want = 0; m_await = 0; m_pulse = 0; m_ovr = 0; m_to = 0;
      m_data = '0; m_run = 0; m_wait = 0;
      return;
    end
    tick   = en && ((m_run % CLK_DIV) == CLK_DIV - 1);
    idle   = !(m_want || m_await || m_pulse);
    hit    = m_await && rsp_valid && (rsp_ch == 5'(CHANNEL));
    expire = 0;
`ifdef ADC_SCHED_TIMEOUT_EN
    expire = m_await && !hit && (m_wait + 1 == TIMEOUT_CYCLES);
`endif
    m_ovr   = (m_ovr && !clr) || (tick && !idle);
    m_to    = (m_to && !clr) || expire;
    if (hit) m_data = rsp_data;
    n_await = m_await ? !(hit || expire) : (m_want && ready);
    n_want  = m_want ? !ready : (idle && tick);
    m_wait  = m_await ? m_wait + 1 : 0;
    m_await = n_await;
    m_want  = n_want;
    m_pulse = hit;
    m_run   = en ? m_run + 1 : 0;
  endfunction

  // Advance one clock and compare every output with the model.
  task automatic step();
    logic [23:0] act, exp;
    model_edge();
    @(posedge clk);
    #1;
    act = {command_valid, command_startofpacket, command_endofpacket, command_channel,
           sample_valid, sample_data, busy, overrun, timeout};
    exp = {m_want, m_want, m_want, 5'(CHANNEL), m_pulse, m_data,
           (m_want | m_await | m_pulse), m_ovr, m_to};
    check("model", 32'(act), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1; en = 0; clr = 0; ready = 0; rsp_valid = 0; rsp_ch = 5'(CHANNEL); rsp_data = '0;
    step();
    step();
    check("reset_state", 32'({command_valid, sample_valid, sample_data, busy, overrun, timeout}),
          32'd0);
    rst = 0;
  endtask

  // Enable and wait (bounded) until a command is being requested.
  task automatic wait_cmd();
    en = 1;
    for (int i = 0; i < 4 * CLK_DIV && command_valid !== 1'b1; i++) step();
    check("cmd_seen", 32'(command_valid), 32'd1);
  endtask

  typedef struct {
    logic        rsp_valid;
    logic [11:0] rsp_data;
    logic        exp_cmd;
    logic        exp_sv;
    logic        exp_busy;
    logic [11:0] exp_data;
  } vec_t;

  localparam int NumVec = 23;
  vec_t vecs[NumVec];

  initial begin
    rst = 1; en = 0; clr = 0; ready = 0; rsp_valid = 0; rsp_ch = 5'(CHANNEL); rsp_data = '0;

    // Steady sampling: tick in cycle 7 (mod 8), command in cycle 8, response 3 cycles
    // later, sample pulse seen after that cycle's edge, idle again one cycle after.
    for (int i = 0; i < NumVec; i++) begin
      vecs[i].rsp_valid = (i >= 8) && (i % 8 == 3);
      vecs[i].rsp_data  = vecs[i].rsp_valid ? 12'hABC : 12'h000;
      vecs[i].exp_cmd   = (i % 8 == 7);
      vecs[i].exp_sv    = (i >= 8) && (i % 8 == 3);
      vecs[i].exp_busy  = (i % 8 == 7) || ((i >= 8) && (i % 8 <= 3));
      vecs[i].exp_data  = (i >= 11) ? 12'hABC : 12'h000;
    end

    do_reset();
    for (int i = 0; i < NumVec; i++) begin
      en = 1; ready = 1; rsp_ch = 5'(CHANNEL);
      rsp_valid = vecs[i].rsp_valid;
      rsp_data  = vecs[i].rsp_data;
      step();
      check($sformatf("vec%0d_cmd", i), 32'(command_valid), 32'(vecs[i].exp_cmd));
      check($sformatf("vec%0d_sv", i), 32'(sample_valid), 32'(vecs[i].exp_sv));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_data", i), 32'(sample_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'd0);
    end
    rsp_valid = 0;

    // Backpressure: command held while ready is low, also with enable dropped.
    do_reset();
    ready = 0;
    wait_cmd();
    en = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("cmd_hold", 32'(command_valid), 32'd1);
    end
    ready = 1;
    step();
    check("cmd_accept_valid", 32'(command_valid), 32'd0);
    check("cmd_accept_busy", 32'(busy), 32'd1);
    ready = 0; rsp_valid = 1; rsp_data = 12'h5A5;
    step();
    check("bp_sv", 32'(sample_valid), 32'd1);
    check("bp_data", 32'(sample_data), 32'h5A5);
    rsp_valid = 0;
    step();
    check("bp_sv_end", 32'(sample_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);

    // Slow response: the second tick lands mid-conversion and is dropped.
    do_reset();
    ready = 1;
    wait_cmd();
    step();
    for (int k = 0; k < 10; k++) step();
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_no_sv", 32'(sample_valid), 32'd0);
    en = 0; rsp_valid = 1; rsp_data = 12'h321;
    step();
    check("ovr_sv", 32'(sample_valid), 32'd1);
    check("ovr_data", 32'(sample_data), 32'h321);
    rsp_valid = 0;
    step();
    check("ovr_sticky", 32'(overrun), 32'd1);
    clr = 1;
    step();
    clr = 0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Wrong-channel response is ignored.
    do_reset();
    ready = 1;
    wait_cmd();
    en = 0;
    step();
    rsp_valid = 1; rsp_ch = 5'd2; rsp_data = 12'h123;
    step();
    check("ch2_no_sv", 32'(sample_valid), 32'd0);
    check("ch2_busy", 32'(busy), 32'd1);
    rsp_ch = 5'(CHANNEL); rsp_data = 12'h456;
    step();
    check("ch1_sv", 32'(sample_valid), 32'd1);
    check("ch1_data", 32'(sample_data), 32'h456);
    rsp_valid = 0;
    step();
    check("ch1_sv_end", 32'(sample_valid), 32'd0);
    check("ch1_hold", 32'(sample_data), 32'h456);

    // Reset while awaiting the response; the late response must be ignored.
    wait_cmd();
    en = 0;
    step();
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    check("rst_mid", 32'({command_valid, sample_valid, sample_data, busy, overrun, timeout}),
          32'd0);
    rsp_valid = 1; rsp_data = 12'h7FF;
    step();
    check("late_rsp_sv", 32'(sample_valid), 32'd0);
    check("late_rsp_data", 32'(sample_data), 32'd0);
    check("late_rsp_busy", 32'(busy), 32'd0);
    rsp_valid = 0;

    // No response at all.
    do_reset();
    ready = 1;
    wait_cmd();
    en = 0;
    step();
    for (int k = 1; k < 16; k++) begin
      step();
      check("wd_early_busy", 32'(busy), 32'd1);
      check("wd_early_to", 32'(timeout), 32'd0);
    end
    step();
`ifdef ADC_SCHED_TIMEOUT_EN
    check("wd_timeout", 32'(timeout), 32'd1);
    check("wd_idle", 32'(busy), 32'd0);
    check("wd_no_sv", 32'(sample_valid), 32'd0);
    clr = 1;
    step();
    clr = 0;
    check("wd_cleared", 32'(timeout), 32'd0);
`else
    for (int k = 0; k < 4; k++) begin
      step();
      check("no_wd_busy", 32'(busy), 32'd1);
      check("no_wd_to", 32'(timeout), 32'd0);
    end
`endif

    // Randomized traffic against the model.
    do_reset();
    en = 1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) en = ~en;
      clr       = ($urandom_range(0, 29) == 0);
      ready     = ($urandom_range(0, 3) != 0);
      rsp_valid = ($urandom_range(0, 3) == 0);
      rsp_ch    = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'(CHANNEL);
      rsp_data  = 12'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
